// File: rtl/spi_fl_arb.sv
// spi_fl_arb: two-port round-robin arbiter and sequencer in front of a
// single spi_master_fl. It grants one requester, latches its command into
// the fl_* registers, pulses fl_validflag once the master is ready, waits
// for completion (watchdog-guarded), then returns data to the owner.
// Optional feature: define SPI_FL_ARB_WREN_EN to auto-insert a WREN (8'h06)
// command before page program / sector erase / block erase / chip erase.
module spi_fl_arb #(
  parameter int         TIMEOUT       = 4096,
  parameter logic [2:0] CMD_ONLY_TYPE = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_cmd,
  input  logic [23:0] req0_addr,
  input  logic [2:0]  req0_type,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_cmd,
  input  logic [23:0] req1_addr,
  input  logic [2:0]  req1_type,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  fl_command,
  output logic [23:0] fl_address,
  output logic [2:0]  fl_commtype,
  output logic [31:0] fl_data_in,
  output logic        fl_validflag,
  input  logic [31:0] fl_data_out,
  input  logic        fl_validflag_out,
  input  logic        fl_tready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef SPI_FL_ARB_WREN_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WREN_ISSUE, WREN_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic          last_q, last_d;     // 1: port 1 was granted last
  logic          owner_q, owner_d;   // port currently holding the master
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic          vf_q, vf_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [2:0]    type_q, type_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          sel;                // winning port in IDLE
  logic          tmo;

`ifdef SPI_FL_ARB_WREN_EN
  logic [7:0] sav_cmd_q, sav_cmd_d;
  logic [2:0] sav_type_q, sav_type_d;

  function automatic logic needs_wren(input logic [7:0] c);
    return (c == 8'h02) || (c == 8'h20) || (c == 8'hD8) || (c == 8'hC7);
  endfunction
`else
  logic [2:0] unused_cmd_only;
  assign unused_cmd_only = CMD_ONLY_TYPE;
`endif

  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  assign sel = req1_valid && (!req0_valid || !last_q);
  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and output decode; pulses default low, everything else holds.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    vf_d    = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    type_d  = type_q;
    wdata_d = wdata_q;
`ifdef SPI_FL_ARB_WREN_EN
    sav_cmd_d  = sav_cmd_q;
    sav_type_d = sav_type_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          rdy0_d  = !sel;
          rdy1_d  = sel;
          last_d  = sel;
          owner_d = sel;
          cmd_d   = sel ? req1_cmd   : req0_cmd;
          addr_d  = sel ? req1_addr  : req0_addr;
          type_d  = sel ? req1_type  : req0_type;
          wdata_d = sel ? req1_wdata : req0_wdata;
          state_d = ISSUE;
`ifdef SPI_FL_ARB_WREN_EN
          if (needs_wren(cmd_d)) begin
            sav_cmd_d  = cmd_d;
            sav_type_d = type_d;
            cmd_d      = 8'h06;
            type_d     = CMD_ONLY_TYPE;
            state_d    = WREN_ISSUE;
          end
`endif
        end
      end
      ISSUE: begin
        if (fl_tready) begin
          vf_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fl_validflag_out) begin
          rv0_d   = !owner_q;
          rv1_d   = owner_q;
          rdata_d = fl_data_out;
          rerr_d  = 1'b0;
          state_d = IDLE;
        end else if (tmo) begin
          rv0_d   = !owner_q;
          rv1_d   = owner_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef SPI_FL_ARB_WREN_EN
      WREN_ISSUE: begin
        if (fl_tready) begin
          vf_d    = 1'b1;
          cnt_d   = '0;
          state_d = WREN_WAIT;
        end
      end
      WREN_WAIT: begin
        // WREN completion is silent; restore the real command and issue it.
        if (fl_validflag_out) begin
          cmd_d   = sav_cmd_q;
          type_d  = sav_type_q;
          state_d = ISSUE;
        end else if (tmo) begin
          rv0_d   = !owner_q;
          rv1_d   = owner_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      vf_q    <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
`ifdef SPI_FL_ARB_WREN_EN
      sav_cmd_q  <= '0;
      sav_type_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      vf_q    <= vf_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
`ifdef SPI_FL_ARB_WREN_EN
      sav_cmd_q  <= sav_cmd_d;
      sav_type_q <= sav_type_d;
`endif
    end
  end

  assign req0_ready   = rdy0_q;
  assign req1_ready   = rdy1_q;
  assign rsp0_valid   = rv0_q;
  assign rsp1_valid   = rv1_q;
  assign rsp_data     = rdata_q;
  assign rsp_err      = rerr_q;
  assign fl_command   = cmd_q;
  assign fl_address   = addr_q;
  assign fl_commtype  = type_q;
  assign fl_data_in   = wdata_q;
  assign fl_validflag = vf_q;

endmodule
